alu_operand_sequencer: RTL
==========================

Name: alu_operand_sequencer

Overview:
- Sequencer and result stage wrapped around the combinational 8-bit add/subtract ALU.
- Captures the A and B operands from the shared 8-bit data bus on consecutive cycles and drives the ALU operand, op and flag-enable lines.
- Waits a programmable settle time for the ALU's propagation delay, then latches the 9-bit ALU result into an accumulator and carry/zero flags.
- Signals completion with a one-cycle done pulse.

Parameters:
- SETTLE_CYCLES, 2, clock cycles spent in SETTLE before writeback; legal range 1..15.
- CNT_W, 4, width of the settle counter; must satisfy 2**CNT_W > SETTLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bus_in  input  8  shared data bus; A operand sampled on the start edge, B operand on the following edge.
- start  input  1  begin an operation; honoured only in IDLE.
- op_sel  input  1  sampled with start; 1 = subtract, 0 = add.
- flag_en  input  1  sampled with start; enables carry capture.
- alu_a  output  8  registered A operand to the ALU.
- alu_b  output  8  registered B operand to the ALU.
- alu_op  output  1  registered op to the ALU.
- alu_flagen  output  1  registered flag enable to the ALU.
- alu_res  input  9  ALU result; bit 8 is carry/borrow.
- acc  output  8  accumulator.
- carry_flag  output  1  latched carry/borrow.
- zero_flag  output  1  latched (acc == 0).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in the cycle after writeback.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE.
  - alu_a, alu_b, acc = 8'h00.
  - alu_op, alu_flagen, carry_flag, zero_flag, busy, done = 0.
  - Settle counter = 0.
  - Reset asserted mid-operation aborts it with no writeback.
- States: IDLE -> LOAD_B -> SETTLE -> WRITEBACK -> IDLE.
- IDLE:
  - On the edge where start=1: alu_a <= bus_in, alu_op <= op_sel, alu_flagen <= flag_en; go to LOAD_B.
  - start=0: hold all registers.
- LOAD_B: alu_b <= bus_in; counter <= 0; go to SETTLE. start is ignored.
- SETTLE:
  - counter increments each cycle.
  - Leave for WRITEBACK on the edge where counter == SETTLE_CYCLES-1, i.e. after exactly SETTLE_CYCLES cycles in SETTLE.
  - Operand registers are stable throughout.
- WRITEBACK:
  - acc <= alu_res[7:0].
  - carry_flag <= alu_res[8] & alu_flagen (masked locally as well as in the ALU).
  - zero_flag <= (alu_res[7:0] == 8'h00), updated regardless of flag_en.
  - done <= 1; go to IDLE.
- done is high for exactly one cycle, the first IDLE cycle after writeback.
- busy is combinational from state: 1 in LOAD_B, SETTLE and WRITEBACK.
- Latency: start sampled at edge T; acc/flags/done update at edge T+2+SETTLE_CYCLES.
- Back-to-back operations: start may be asserted in the same cycle done is high; the new A is captured on that edge.
- Operands:
  - alu_a, alu_b and alu_op hold their last values in IDLE; they are not cleared after an operation.
  - acc and flags hold until the next writeback.
- Arithmetic is owned by the ALU. The sequencer never recomputes it; it trusts alu_res after settling.
  - Subtract borrow appears as alu_res[8]=1, e.g. 8'h05-8'h07 -> 9'h1FE.
- Start pulses while busy=1 are dropped, not queued.

Optional Feature:
- Macro: ALU_ACC_CHAIN_EN.
- With the macro defined:
  - Extra input port use_acc (1 bit), sampled with start.
  - When use_acc=1, alu_a <= acc instead of bus_in; bus_in is ignored on the start edge.
  - Sequence and latency are otherwise identical, which allows running sums (acc = acc ± B).
- Without the macro: the use_acc port does not exist and A always comes from bus_in.

Decomposition:
- Shared package alu_seq_pkg holds:
  - State enum: IDLE=2'd0, LOAD_B=2'd1, SETTLE=2'd2, WRITEBACK=2'd3.
  - Constants DATA_W=8 and RES_W=9.
- No sub-module is needed: FSM, settle counter and result registers form a single module.
- The ALU is instantiated by the parent, not inside this block.

Test Plan:
- Reset mid-SETTLE:
  - Stimulus: start A=8'h0F, B=8'h01, then pull rst_n low while in SETTLE.
  - Response: acc=0, flags=0, busy=0, done never pulses.
- Add with flags:
  - Stimulus: start op=0, flag_en=1, A=8'h0F, B=8'h01, SETTLE_CYCLES=2.
  - Response: acc=8'h10, carry=0, zero=0, done pulses exactly 4 cycles after the start edge.
- Add overflow, flags enabled:
  - Stimulus: A=8'hFF, B=8'h01, op=0, flag_en=1.
  - Response: acc=8'h00, carry=1, zero=1.
- Add overflow, flags disabled:
  - Stimulus: same operands with flag_en=0.
  - Response: acc=8'h00, carry=0, zero=1.
- Subtract with borrow:
  - Stimulus: A=8'h05, B=8'h07, op=1, flag_en=1.
  - Response: acc=8'hFE, carry=1, zero=0.
- Start while busy:
  - Stimulus: pulse start with bus_in=8'hAA during SETTLE.
  - Response: ignored; result is still from the original operands; a start held in the done cycle launches the next operation immediately.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Holds the FSM state encoding and the data/result widths.
package alu_seq_pkg;

   localparam int DATA_W = 8;
   localparam int RES_W  = 9;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_B    = 2'd1,
      SETTLE    = 2'd2,
      WRITEBACK = 2'd3
   } state_e;

   // Every state except IDLE counts as busy.
   function automatic logic state_busy(input state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/alu_operand_sequencer.sv
// Sequencer/result stage around an external combinational add/sub ALU.
// Ports: clk, rst_n (async low); bus_in, start, op_sel, flag_en in;
//   alu_a/alu_b/alu_op/alu_flagen to ALU; alu_res from ALU;
//   acc, carry_flag, zero_flag, busy, done out.
// Optional: define ALU_ACC_CHAIN_EN to add use_acc (A taken from acc).
module alu_operand_sequencer
   import alu_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              start,
   input  logic              op_sel,
   input  logic              flag_en,
`ifdef ALU_ACC_CHAIN_EN
   input  logic              use_acc,
`endif
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_op,
   output logic              alu_flagen,
   input  logic [RES_W-1:0]  alu_res,
   output logic [DATA_W-1:0] acc,
   output logic              carry_flag,
   output logic              zero_flag,
   output logic              busy,
   output logic              done
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              op_q, op_d;
   logic              fe_q, fe_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              c_q, c_d;
   logic              z_q, z_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] a_src;

`ifdef ALU_ACC_CHAIN_EN
   // Running sums: A may come from the accumulator instead of the bus.
   assign a_src = use_acc ? acc_q : bus_in;
`else
   assign a_src = bus_in;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      fe_d    = fe_q;
      acc_d   = acc_q;
      c_d     = c_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a_src;
               op_d    = op_sel;
               fe_d    = flag_en;
               state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            b_d     = bus_in;
            cnt_d   = '0;
            state_d = SETTLE;
         end
         SETTLE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = WRITEBACK;
            end
         end
         WRITEBACK: begin
            acc_d   = alu_res[DATA_W-1:0];
            // Carry is masked here too, not only inside the ALU.
            c_d     = alu_res[DATA_W] & fe_q;
            z_d     = (alu_res[DATA_W-1:0] == '0);
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         fe_q    <= 1'b0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         fe_q    <= fe_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         z_q     <= z_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_op     = op_q;
   assign alu_flagen = fe_q;
   assign acc        = acc_q;
   assign carry_flag = c_q;
   assign zero_flag  = z_q;
   assign done       = done_q;
   assign busy       = state_busy(state_q);

endmodule
